// File: rtl/cpu_step_controller_pkg.sv
// rtl/cpu_step_controller_pkg.sv - shared state encodings and widths for the CPU step controller
package cpu_step_controller_pkg;

    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/cpu_step_controller_if.sv
// rtl/cpu_step_controller_if.sv - key, mode, breakpoint and status signals of the step controller
interface cpu_step_controller_if #(
    parameter int PC_W = 8
);
    import cpu_step_controller_pkg::*;

    logic                  key_n;
    logic                  run_mode;
    logic                  bp_en;
    logic [PC_W-1:0]       bp_addr;
    logic [PC_W-1:0]       pc;
    logic                  step_en;
    logic                  halted;
    logic [STEP_CNT_W-1:0] step_count;

    // Board / CPU side: drives key, mode, breakpoint and PC; consumes status.
    modport master (
        output key_n, run_mode, bp_en, bp_addr, pc,
        input  step_en, halted, step_count
    );

    // Controller side.
    modport slave (
        input  key_n, run_mode, bp_en, bp_addr, pc,
        output step_en, halted, step_count
    );
endinterface

// File: rtl/cpu_step_controller_key_debouncer.sv
// rtl/cpu_step_controller_key_debouncer.sv - step key synchroniser, debouncer and press detector
module key_debouncer #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             pressed_sync;
    logic [CNT_W-1:0] cnt;

    assign pressed_sync = ~sync2;

    // Two-flop synchroniser, then accept the new level only after it has
    // differed from the current one for CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (pressed_sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CYCLES - 1)) begin
                cnt   <= '0;
                level <= pressed_sync;
                press <= pressed_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cpu_step_controller.sv
// rtl/cpu_step_controller.sv - single-step / free-run / breakpoint advance enable for the CPU
module cpu_step_controller
    import cpu_step_controller_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int RUN_HZ      = 4,
    parameter int PC_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cpu_step_controller_if.slave   bus
);
    localparam int DEBOUNCE_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int RUN_DIV         = CLK_FREQ / RUN_HZ;
    localparam int RUN_W           = $clog2(RUN_DIV);

    state_t                state;
    logic                  step_en;
    logic                  halted;
    logic [STEP_CNT_W-1:0] step_count;
    logic [RUN_W-1:0]      rate_cnt;

    logic                  key_level;
    logic                  key_press;
    logic                  press;
    logic                  tick;
    logic                  bp_hit;
    logic [PC_W-1:0]       pc_cur;
    logic [PC_W-1:0]       bp_cur;

    key_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.key_n),
        .level (key_level),
        .press (key_press)
    );

    // A press pulse always coincides with the debounced level going high.
    assign press  = key_press & key_level;
    assign tick   = (rate_cnt == RUN_W'(RUN_DIV - 1));
    assign pc_cur = bus.pc;
    assign bp_cur = bus.bp_addr;
    assign bp_hit = bus.bp_en && (pc_cur == bp_cur);

    // Mode FSM with rate divider and step counter; all outputs registered so
    // step_en lands the cycle after its cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_STEP;
            step_en    <= 1'b0;
            halted     <= 1'b0;
            step_count <= '0;
            rate_cnt   <= '0;
        end else begin
            step_en <= 1'b0;
            case (state)
                S_STEP: begin
                    if (press) begin
                        step_en    <= 1'b1;
                        step_count <= step_count + 1'b1;
                    end
                    if (bus.run_mode) begin
                        state    <= S_RUN;
                        rate_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (!bus.run_mode) begin
                        state    <= S_STEP;
                        rate_cnt <= '0;
                    end else if (tick) begin
                        rate_cnt <= '0;
                        if (bp_hit) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            step_en    <= 1'b1;
                            step_count <= step_count + 1'b1;
                        end
                    end else begin
                        rate_cnt <= rate_cnt + 1'b1;
                    end
                end
                S_HALT: begin
                    if (!bus.run_mode) begin
                        state  <= S_STEP;
                        halted <= 1'b0;
                    end else if (press) begin
                        step_en    <= 1'b1;
                        step_count <= step_count + 1'b1;
                        halted     <= 1'b0;
                        state      <= S_RUN;
                        rate_cnt   <= '0;
                    end
                end
                default: begin
                    state  <= S_STEP;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.step_en    = step_en;
    assign bus.halted     = halted;
    assign bus.step_count = step_count;
endmodule
